// File: rtl/alu_rr_scheduler.sv
// Round-robin front end that shares one external combinational ALU between NUM_REQ requesters.
// Optional macro ALU_SCHED_ILLEGAL_OP_EN: opcodes >= 13 bypass the ALU and answer with rsp_err.
module alu_rr_scheduler #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned MUL_LAT = 3
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_REQ-1:0]         req_valid,
    output logic [NUM_REQ-1:0]         req_ready,
    input  logic [4*NUM_REQ-1:0]       req_opcode,
    input  logic [WIDTH*NUM_REQ-1:0]   req_a,
    input  logic [WIDTH*NUM_REQ-1:0]   req_b,
    input  logic [5*NUM_REQ-1:0]       req_shamt,
    output logic [3:0]                 alu_opcode,
    output logic [WIDTH-1:0]           alu_input1,
    output logic [WIDTH-1:0]           alu_input2,
    output logic [4:0]                 alu_shiftValue,
    input  logic [WIDTH-1:0]           alu_result,
    input  logic                       alu_carryFlag,
    input  logic                       alu_zeroFlag,
    input  logic                       alu_overFlowFlag,
    output logic                       rsp_valid,
    input  logic                       rsp_ready,
    output logic [$clog2(NUM_REQ)-1:0] rsp_id,
    output logic [WIDTH-1:0]           rsp_result,
    output logic                       rsp_carry,
    output logic                       rsp_zero,
    output logic                       rsp_ovf,
    output logic                       rsp_err,
    output logic                       busy
);

    localparam int unsigned IdW  = $clog2(NUM_REQ);
    localparam int unsigned CntW = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;
    localparam logic [3:0]  OpSub = 4'd1;
    localparam logic [3:0]  OpMul = 4'd4;
    localparam logic [3:0]  OpAdd = 4'd5;

    typedef enum logic [1:0] {StIdle, StExec, StResp} state_e;

    state_e            state_q, state_d;
    logic [IdW-1:0]    ptr_q, ptr_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [3:0]        op_q, op_d;
    logic [WIDTH-1:0]  a_q, a_d, b_q, b_d;
    logic [4:0]        sh_q, sh_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [IdW-1:0]    rsp_id_q, rsp_id_d;
    logic [WIDTH-1:0]  rsp_result_q, rsp_result_d;
    logic              rsp_carry_q, rsp_carry_d;
    logic              rsp_zero_q, rsp_zero_d;
    logic              rsp_ovf_q, rsp_ovf_d;
    logic              rsp_err_q, rsp_err_d;

    logic [NUM_REQ-1:0] hi_mask, hi_valid, pick_vec;
    logic [IdW-1:0]     win;
    logic               can_grant;
    logic [3:0]         sel_op;
    logic [WIDTH-1:0]   sel_a, sel_b;
    logic [4:0]         sel_sh;
    logic               sel_illegal;
    logic               flagged_op;

    // Requesters above the pointer win first; otherwise wrap to the lowest valid index.
    always_comb begin
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            hi_mask[i] = (i > int'(ptr_q));
        end
        hi_valid = req_valid & hi_mask;
        pick_vec = (|hi_valid) ? hi_valid : req_valid;
        win      = '0;
        for (int i = int'(NUM_REQ) - 1; i >= 0; i--) begin
            if (pick_vec[i]) begin
                win = IdW'(i);
            end
        end
        can_grant = rst_n && (state_q == StIdle) && (|req_valid);
        sel_op    = '0;
        sel_a     = '0;
        sel_b     = '0;
        sel_sh    = '0;
        req_ready = '0;
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            if (win == IdW'(i)) begin
                sel_op       = req_opcode[4*i +: 4];
                sel_a        = req_a[WIDTH*i +: WIDTH];
                sel_b        = req_b[WIDTH*i +: WIDTH];
                sel_sh       = req_shamt[5*i +: 5];
                req_ready[i] = can_grant;
            end
        end
    end

`ifdef ALU_SCHED_ILLEGAL_OP_EN
    assign sel_illegal = (sel_op >= 4'd13);
`else
    assign sel_illegal = 1'b0;
`endif

    assign flagged_op = (op_q == OpAdd) || (op_q == OpSub);

    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        cnt_d        = cnt_q;
        op_d         = op_q;
        a_d          = a_q;
        b_d          = b_q;
        sh_d         = sh_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_id_d     = rsp_id_q;
        rsp_result_d = rsp_result_q;
        rsp_carry_d  = rsp_carry_q;
        rsp_zero_d   = rsp_zero_q;
        rsp_ovf_d    = rsp_ovf_q;
        rsp_err_d    = rsp_err_q;
        unique case (state_q)
            StIdle: begin
                if (can_grant) begin
                    ptr_d = win;
                    if (sel_illegal) begin
                        // ALU operand registers are left untouched for rejected opcodes.
                        state_d      = StResp;
                        rsp_id_d     = win;
                        rsp_result_d = '0;
                        rsp_carry_d  = 1'b0;
                        rsp_zero_d   = 1'b0;
                        rsp_ovf_d    = 1'b0;
                        rsp_err_d    = 1'b1;
                    end else begin
                        state_d = StExec;
                        op_d    = sel_op;
                        a_d     = sel_a;
                        b_d     = sel_b;
                        sh_d    = sel_sh;
                        cnt_d   = (sel_op == OpMul) ? CntW'(MUL_LAT - 1) : '0;
                    end
                end
            end
            StExec: begin
                if (cnt_q == '0) begin
                    state_d      = StResp;
                    rsp_valid_d  = 1'b1;
                    rsp_id_d     = ptr_q;
                    rsp_result_d = alu_result;
                    rsp_zero_d   = alu_zeroFlag;
                    rsp_carry_d  = flagged_op & alu_carryFlag;
                    rsp_ovf_d    = flagged_op & alu_overFlowFlag;
                    rsp_err_d    = 1'b0;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            StResp: begin
                // A rejected opcode enters here with rsp_valid low and raises it one edge later.
                if (!rsp_valid_q) begin
                    rsp_valid_d = 1'b1;
                end else if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            ptr_q        <= IdW'(NUM_REQ - 1);
            cnt_q        <= '0;
            op_q         <= '0;
            a_q          <= '0;
            b_q          <= '0;
            sh_q         <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_id_q     <= '0;
            rsp_result_q <= '0;
            rsp_carry_q  <= 1'b0;
            rsp_zero_q   <= 1'b0;
            rsp_ovf_q    <= 1'b0;
            rsp_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            cnt_q        <= cnt_d;
            op_q         <= op_d;
            a_q          <= a_d;
            b_q          <= b_d;
            sh_q         <= sh_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_id_q     <= rsp_id_d;
            rsp_result_q <= rsp_result_d;
            rsp_carry_q  <= rsp_carry_d;
            rsp_zero_q   <= rsp_zero_d;
            rsp_ovf_q    <= rsp_ovf_d;
            rsp_err_q    <= rsp_err_d;
        end
    end

    assign alu_opcode     = op_q;
    assign alu_input1     = a_q;
    assign alu_input2     = b_q;
    assign alu_shiftValue = sh_q;
    assign rsp_valid      = rsp_valid_q;
    assign rsp_id         = rsp_id_q;
    assign rsp_result     = rsp_result_q;
    assign rsp_carry      = rsp_carry_q;
    assign rsp_zero       = rsp_zero_q;
    assign rsp_ovf        = rsp_ovf_q;
    assign busy           = (state_q != StIdle);

`ifdef ALU_SCHED_ILLEGAL_OP_EN
    assign rsp_err = rsp_err_q;
`else
    assign rsp_err = 1'b0;
`endif

endmodule

// File: tb/tb_alu_rr_scheduler.sv
// Randomised scoreboard bench for alu_rr_scheduler with a behavioural ALU and arbitration model.
module tb_alu_rr_scheduler;

    localparam int N       = 4;
    localparam int W       = 32;
    localparam int MUL_LAT = 3;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [N-1:0]   req_valid, req_ready;
    logic [4*N-1:0] req_opcode;
    logic [W*N-1:0] req_a, req_b;
    logic [5*N-1:0] req_shamt;
    logic [3:0]     alu_opcode;
    logic [W-1:0]   alu_input1, alu_input2, alu_result;
    logic [4:0]     alu_shiftValue;
    logic           alu_carryFlag, alu_zeroFlag, alu_overFlowFlag;
    logic           rsp_valid, rsp_ready;
    logic [1:0]     rsp_id;
    logic [W-1:0]   rsp_result;
    logic           rsp_carry, rsp_zero, rsp_ovf, rsp_err, busy;

    always #5 clk = ~clk;

    alu_rr_scheduler #(.NUM_REQ(N), .WIDTH(W), .MUL_LAT(MUL_LAT)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_opcode(req_opcode),
        .req_a(req_a), .req_b(req_b), .req_shamt(req_shamt),
        .alu_opcode(alu_opcode), .alu_input1(alu_input1), .alu_input2(alu_input2),
        .alu_shiftValue(alu_shiftValue), .alu_result(alu_result),
        .alu_carryFlag(alu_carryFlag), .alu_zeroFlag(alu_zeroFlag),
        .alu_overFlowFlag(alu_overFlowFlag),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_result(rsp_result), .rsp_carry(rsp_carry), .rsp_zero(rsp_zero),
        .rsp_ovf(rsp_ovf), .rsp_err(rsp_err), .busy(busy)
    );

    // External ALU: non ADD/SUB opcodes drive junk carry/overflow so masking is exercised.
    function automatic logic [W+2:0] alu_model(input logic [3:0] op, input logic [W-1:0] a,
                                               input logic [W-1:0] b, input logic [4:0] sh);
        logic [W-1:0] r;
        logic [W:0]   t;
        logic         c, v;
        r = '0; t = '0; c = 1'b0; v = 1'b0;
        case (op)
            4'd0:  r = a ^ b;
            4'd1:  begin
                t = {1'b0, a} - {1'b0, b}; r = t[W-1:0]; c = t[W];
                v = (a[W-1] != b[W-1]) && (r[W-1] != a[W-1]);
            end
            4'd2:  r = a & b;
            4'd3:  r = a << sh;
            4'd4:  r = a * b;
            4'd5:  begin
                t = {1'b0, a} + {1'b0, b}; r = t[W-1:0]; c = t[W];
                v = (a[W-1] == b[W-1]) && (r[W-1] != a[W-1]);
            end
            4'd6:  r = a >> sh;
            4'd7:  r = $signed(a) >>> sh;
            4'd8:  r = (a << sh) | (a >> (W - int'(sh)));
            4'd9:  r = (a >> sh) | (a << (W - int'(sh)));
            4'd10: r = ~(a & b);
            4'd11: r = ~(a | b);
            4'd12: r = a | b;
            default: r = '0;
        endcase
        if (op != 4'd1 && op != 4'd5 && op < 4'd13) begin
            c = r[0];
            v = r[W-1];
        end
        return {c, (r == '0), v, r};
    endfunction

    assign {alu_carryFlag, alu_zeroFlag, alu_overFlowFlag, alu_result} =
        alu_model(alu_opcode, alu_input1, alu_input2, alu_shiftValue);

    typedef struct {
        logic [1:0]   id;
        logic [3:0]   op;
        logic [W-1:0] a, b;
        logic [4:0]   sh;
        logic [W-1:0] res;
        logic         c, z, v, e;
        int           lat;
        int           acc;
    } exp_t;

    function automatic exp_t make_exp(input int id, input logic [3:0] op, input logic [W-1:0] a,
                                      input logic [W-1:0] b, input logic [4:0] sh, input int acc);
        exp_t         x;
        logic [W+2:0] m;
        m     = alu_model(op, a, b, sh);
        x.id  = 2'(id); x.op = op; x.a = a; x.b = b; x.sh = sh; x.acc = acc;
        x.res = m[W-1:0];
        x.z   = m[W+1];
        x.c   = (op == 4'd5 || op == 4'd1) ? m[W+2] : 1'b0;
        x.v   = (op == 4'd5 || op == 4'd1) ? m[W] : 1'b0;
        x.e   = 1'b0;
        x.lat = (op == 4'd4) ? MUL_LAT : 1;
`ifdef ALU_SCHED_ILLEGAL_OP_EN
        if (op >= 4'd13) begin
            x.res = '0; x.c = 1'b0; x.z = 1'b0; x.v = 1'b0; x.e = 1'b1; x.lat = 1;
        end
`endif
        return x;
    endfunction

    // Scoreboard / monitor state (written only by the monitor).
    exp_t         sb[$];
    exp_t         ex;
    int           n_cmp = 0, n_fail = 0, n_rsp = 0;
    int           cyc = 0, last = N - 1, idx, w;
    bit           found, rsp_seen = 1'b0;
    logic [N-1:0] exp_ready;
    // Stimulus-owned flags.
    bit           done = 1'b0;
    int           tmo = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got %h expected %h", name, cyc, act, req);
        end
    endtask

    always @(negedge clk) begin
        cyc++;
        if (!rst_n) begin
            chk("reset_outputs", {req_ready, busy, rsp_valid, rsp_id, rsp_result, rsp_carry,
                rsp_zero, rsp_ovf, rsp_err, alu_opcode, alu_input1, alu_input2, alu_shiftValue},
                '0);
            sb.delete();
            last     = N - 1;
            rsp_seen = 1'b0;
        end else begin
            chk("busy", busy, sb.size() != 0);
            exp_ready = '0;
            found     = 1'b0;
            w         = 0;
            if (sb.size() == 0) begin
                for (int k = 1; k <= N; k++) begin
                    idx = (last + k) % N;
                    if (!found && req_valid[idx]) begin
                        found = 1'b1;
                        w     = idx;
                    end
                end
                if (found) exp_ready[w] = 1'b1;
            end
            chk("grant", req_ready, exp_ready);
            if (sb.size() != 0 && !rsp_valid && !sb[0].e) begin
                chk("alu_hold", {alu_opcode, alu_input1, alu_input2, alu_shiftValue},
                    {sb[0].op, sb[0].a, sb[0].b, sb[0].sh});
            end
            if (rsp_valid) begin
                if (sb.size() == 0) begin
                    chk("spurious_rsp", rsp_valid, 1'b0);
                end else begin
                    ex = sb[0];
                    if (!rsp_seen) begin
                        chk("latency", cyc - ex.acc - 1, ex.lat);
                        rsp_seen = 1'b1;
                    end
                    chk("rsp", {rsp_id, rsp_result, rsp_carry, rsp_zero, rsp_ovf, rsp_err},
                        {ex.id, ex.res, ex.c, ex.z, ex.v, ex.e});
                    if (rsp_ready) begin
                        void'(sb.pop_front());
                        rsp_seen = 1'b0;
                        n_rsp++;
                    end
                end
            end
            if (found && req_ready == exp_ready) begin
                sb.push_back(make_exp(w, req_opcode[4*w +: 4], req_a[W*w +: W], req_b[W*w +: W],
                                      req_shamt[5*w +: 5], cyc));
                last = w;
            end
        end
        if (done || cyc > 20000) begin
            chk("stim_timeouts", tmo, 0);
            chk("drained", sb.size(), 0);
            chk("enough_rsp", n_rsp > 40, 1'b1);
            if (!done) begin
                n_fail++;
                $display("FAIL global_timeout: stimulus did not finish by cycle %0d", cyc);
            end
            $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
            $finish;
        end
    end

    // ---------------- stimulus ----------------
    logic [N-1:0] g;

    task automatic step();
        @(negedge clk);
        g = req_valid & req_ready;
        @(posedge clk);
        #1;
        req_valid = req_valid & ~g;
    endtask

    task automatic issue(input int i, input logic [3:0] op, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic [4:0] sh);
        req_opcode[4*i +: 4] = op;
        req_a[W*i +: W]      = a;
        req_b[W*i +: W]      = b;
        req_shamt[5*i +: 5]  = sh;
        req_valid[i]         = 1'b1;
    endtask

    task automatic wait_idle(input int max_cyc);
        int n;
        n = 0;
        step();
        while ((req_valid != '0 || sb.size() != 0) && n < max_cyc) begin
            step();
            n++;
        end
        if (n >= max_cyc) tmo++;
    endtask

    function automatic logic [W-1:0] rnd_val();
        case ($urandom_range(0, 5))
            0:       return '0;
            1:       return '1;
            2:       return 32'h7FFF_FFFF;
            3:       return 32'h8000_0000;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int grants, n;
        logic [W-1:0] v;
        req_valid = '0; req_opcode = '0; req_a = '0; req_b = '0; req_shamt = '0;
        rsp_ready = 1'b1;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;

        issue(0, 4'd5, 32'h7FFF_FFFF, 32'd1, 5'd0);
        wait_idle(50);

        for (int i = 0; i < N; i++) issue(i, 4'(2 * $urandom_range(0, 6)), rnd_val(), rnd_val(), 5'($urandom));
        grants = 0;
        n      = 0;
        while (grants < 8 && n < 100) begin
            step();
            n++;
            for (int i = 0; i < N; i++) begin
                if (g[i]) begin
                    grants++;
                    if (grants < 8) issue(i, 4'd5, rnd_val(), rnd_val(), 5'd0);
                end
            end
        end
        if (n >= 100) tmo++;
        req_valid = '0;
        wait_idle(50);

        issue(2, 4'd4, 32'd6, 32'd7, 5'd0);
        wait_idle(50);

        v = $urandom;
        rsp_ready = 1'b0;
        issue(1, 4'd0, v, v, 5'd3);
        issue(3, 4'd12, rnd_val(), rnd_val(), 5'd0);
        repeat (7) step();
        rsp_ready = 1'b1;
        wait_idle(50);

        issue(1, 4'd4, $urandom, $urandom, 5'd0);
        n = 0;
        do begin
            step();
            n++;
        end while (!g[1] && n < 50);
        if (n >= 50) tmo++;
        #2 rst_n = 1'b0;
        step();
        #2 rst_n = 1'b1;
        issue(3, 4'd1, rnd_val(), rnd_val(), 5'd0);
        issue(0, 4'd5, rnd_val(), rnd_val(), 5'd0);
        wait_idle(50);

        issue(2, 4'd14, $urandom, $urandom, 5'($urandom));
        wait_idle(50);

        repeat (600) begin
            for (int i = 0; i < N; i++) begin
                if (!req_valid[i] && $urandom_range(0, 2) == 0)
                    issue(i, 4'($urandom_range(0, 15)), rnd_val(), rnd_val(), 5'($urandom));
                else if (req_valid[i] && $urandom_range(0, 19) == 0)
                    req_valid[i] = 1'b0;
            end
            rsp_ready = ($urandom_range(0, 3) != 0);
            step();
        end
        req_valid = '0;
        rsp_ready = 1'b1;
        wait_idle(50);
        done = 1'b1;
    end

endmodule
